div_iter: RTL
=============

DIV_ITER -- requirements
Module: div_iter

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, rising-edge active.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port in_valid, input, 1 bit: requester presents an operation.
REQ-004 SHALL have port in_ready, output, 1 bit: block can accept an operation.
REQ-005 SHALL have port div_op, input, 4 bits: one-hot opcode; bit0 DIV.W, bit1 MOD.W, bit2 DIV.WU, bit3 MOD.WU.
REQ-006 SHALL have port dividend, input, 32 bits: dividend operand.
REQ-007 SHALL have port divisor, input, 32 bits: divisor operand.
REQ-008 SHALL have port out_valid, output, 1 bit: result is available.
REQ-009 SHALL have port out_ready, input, 1 bit: requester consumes the result.
REQ-010 SHALL have port quotient, output, 32 bits: quotient result.
REQ-011 SHALL have port remainder, output, 32 bits: remainder result.

Function
REQ-012 SHALL implement an FSM with states IDLE, CALC and DONE.
REQ-013 SHALL drive in_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-014 SHALL accept an operation on a rising edge where in_valid&in_ready: latch the operand magnitudes, signs and signedness, clear the 6-bit iteration counter, go to CALC.
REQ-015 SHALL treat the operation as signed when div_op[0]|div_op[1]; otherwise unsigned, including zero or multi-hot div_op.
REQ-016 SHALL perform one restoring-division step on the 32-bit magnitudes per CALC cycle, 32 steps total.
REQ-017 SHALL enter DONE on the 32nd CALC edge, so out_valid rises exactly 32 cycles after the accepting edge.
REQ-018 SHALL produce quotient and remainder both, whatever the op; the consumer selects.
REQ-019 SHALL use truncating signed semantics: quotient negated when the operand signs differ; remainder takes the dividend's sign.
REQ-020 SHALL, for divisor==0 (any op), return quotient=0xFFFFFFFF and remainder=dividend.
REQ-021 SHALL, for signed 0x80000000 / 0xFFFFFFFF, return quotient=0x80000000 and remainder=0 (wrap).
REQ-022 SHALL hold quotient, remainder and out_valid stable while out_valid&!out_ready.
REQ-023 SHALL return from DONE to IDLE on the edge where out_valid&out_ready; in_ready rises the following cycle (no same-cycle accept).
REQ-024 SHALL ignore in_valid outside IDLE; operand changes after acceptance SHALL NOT affect the result.
REQ-025 SHALL ignore out_ready outside DONE.

Reset
REQ-026 SHALL, on rst assertion, immediately force state IDLE, counter 0, out_valid 0, quotient 0 and remainder 0.
REQ-027 SHALL hold in_ready at 0 while rst is asserted and drive it to 1 in the first cycle after release.
REQ-028 SHALL abort an in-flight operation on reset mid-CALC or mid-DONE, with no result emitted afterwards.

Structure
REQ-029 SHALL take its state encoding, the div_op bit indices and the width constant (32) from shared package div_pkg.
REQ-030 SHALL be a single module with no sub-module; magnitude and sign-fix logic stay inline.

Verification
REQ-031 SHALL cover: DIV.W 7 / 0xFFFFFFFE -> quotient 0xFFFFFFFD, remainder 1, out_valid exactly 32 cycles after accept.
REQ-032 SHALL cover: MOD.WU 0xFFFFFFFF / 0x10 -> quotient 0x0FFFFFFF, remainder 0xF; MOD.W 0xFFFFFFF9 / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
REQ-033 SHALL cover: DIV.WU 0x1234 / 0 -> quotient 0xFFFFFFFF, remainder 0x1234; DIV.W 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0.
REQ-034 SHALL cover: out_ready held low 5 cycles after out_valid -> outputs unchanged, in_ready 0 throughout, and in_valid pulses with new operands during CALC/DONE ignored.
REQ-035 SHALL cover: rst asserted at iteration 10 -> out_valid 0 immediately, no result appears; after release in_ready=1 and a new DIV.WU 100 / 7 returns quotient 14, remainder 2.
REQ-036 SHALL cover: back-to-back operations with in_valid held high -> each accepted one cycle after the previous result handshake, results correct and in order.

Source files
------------

// File: rtl/div_pkg.sv
// Shared constants and types for the iterative 32-bit divider.
// State encoding, opcode bit positions and datapath widths live here.
package div_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 6;

    localparam int OP_DIV_W  = 0;
    localparam int OP_MOD_W  = 1;
    localparam int OP_DIVU_W = 2;
    localparam int OP_MODU_W = 3;

    localparam logic [3:0] SIGNED_MASK =
        (4'b1 << OP_DIV_W) | (4'b1 << OP_MOD_W);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_iter.sv
// Iterative restoring divider: one quotient bit per cycle on magnitudes,
// sign fix-up on the final step, valid/ready on both sides.
module div_iter
    import div_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      div_op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN-1:0]   dvs_q, dvs_d;
    logic              negq_q, negq_d;
    logic              negr_q, negr_d;
    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   quotient_q, quotient_d;
    logic [XLEN-1:0]   remainder_q, remainder_d;

    logic              signed_op;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic [XLEN:0]     trial;
    logic [XLEN-1:0]   step_rem;
    logic [XLEN-1:0]   step_quo;

    assign signed_op = |(div_op & SIGNED_MASK);
    assign a_neg     = signed_op & dividend[XLEN-1];
    assign b_neg     = signed_op & divisor[XLEN-1];
    assign a_mag     = a_neg ? (-dividend) : dividend;
    assign b_mag     = b_neg ? (-divisor) : divisor;

    // Borrow out of the trial subtract means the divisor did not fit.
    assign trial    = {rem_q, quo_q[XLEN-1]} - {1'b0, dvs_q};
    assign step_rem = trial[XLEN] ? {rem_q[XLEN-2:0], quo_q[XLEN-1]}
                                  : trial[XLEN-1:0];
    assign step_quo = {quo_q[XLEN-2:0], ~trial[XLEN]};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        negq_d      = negq_q;
        negr_d      = negr_q;
        out_valid_d = out_valid_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    rem_d   = '0;
                    quo_d   = a_mag;
                    dvs_d   = b_mag;
                    // Divide-by-zero keeps the all-ones quotient unsigned.
                    negq_d  = (a_neg ^ b_neg) & (|divisor);
                    negr_d  = a_neg;
                    cnt_d   = '0;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    quotient_d  = negq_q ? (-step_quo) : step_quo;
                    remainder_d = negr_q ? (-step_rem) : step_rem;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            negq_q      <= 1'b0;
            negr_q      <= 1'b0;
            out_valid_q <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            negq_q      <= negq_d;
            negr_q      <= negr_d;
            out_valid_q <= out_valid_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE) & ~rst;
    assign out_valid = out_valid_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;

endmodule
